// File: rtl/i2c_xfer_sequencer_if.sv
// APB slave port plus the i2c_master core register port of the transfer sequencer.
// The slave modport is the sequencer's view. The master modport is the surrounding system: the CPU and the core.
interface i2c_xfer_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PIRQ;
  logic [5:0]  core_a;
  logic [7:0]  core_di;
  logic        core_we;
  logic        core_re;
  logic [7:0]  core_do;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, core_do,
    output PRDATA, PREADY, PIRQ, core_a, core_di, core_we, core_re
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, core_do,
    input  PRDATA, PREADY, PIRQ, core_a, core_di, core_we, core_re
  );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// APB-controlled sequencer that runs whole register-style I2C write/read transfers
// on an i2c_master core by driving its register port and polling its SR.
module i2c_xfer_sequencer #(
  parameter logic [15:0] PRESCALE_RST = 16'h0063
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  i2c_xfer_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_OFF, S_INIT, S_IDLE, S_TX, S_CR, S_SRRD, S_SRCHK,
    S_STOP, S_STWAIT, S_RXRD, S_RXCAP, S_DIS
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_prescale;
  logic        r_en, r_ie, r_done, r_nack, r_al, r_is_read, r_stw_chk;
  logic [6:0]  r_saddr;
  logic [7:0]  r_regaddr, r_wdata, r_rdata;
  logic [1:0]  r_step, r_init_cnt;

  logic        w_wr, w_busy, w_go, w_last_step, w_final_rd;
  logic        w_step_inc, w_set_al, w_set_nack, w_capture, w_done_set;
  logic [2:0]  w_idx;
  logic [7:0]  w_tx_byte, w_cr_byte;
  logic        w_unused;

  assign w_wr        = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign w_idx       = bus.PADDR[4:2];
  assign w_busy      = r_state inside {S_TX, S_CR, S_SRRD, S_SRCHK, S_STOP, S_STWAIT, S_RXRD, S_RXCAP};
  assign w_go        = w_wr && (w_idx == 3'd5) && (|bus.PWDATA[1:0]) && (r_state == S_IDLE);
  assign w_last_step = r_is_read ? (r_step == 2'd3) : (r_step == 2'd2);
  assign w_final_rd  = r_is_read && (r_step == 2'd3);
  assign w_unused    = ^{bus.PADDR[31:5], bus.PADDR[1:0], bus.PWDATA[31:16]};

  // Step tables: address+W, register index, then data (write) or address+R and receive (read).
  always_comb begin
    unique case (r_step)
      2'd0:    begin w_tx_byte = {r_saddr, 1'b0}; w_cr_byte = 8'h90; end
      2'd1:    begin w_tx_byte = r_regaddr;       w_cr_byte = 8'h10; end
      2'd2:    begin
                 w_tx_byte = r_is_read ? {r_saddr, 1'b1} : r_wdata;
                 w_cr_byte = r_is_read ? 8'h90 : 8'h50;
               end
      default: begin w_tx_byte = 8'h00;           w_cr_byte = 8'h68; end
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_next      = r_state;
    bus.core_we = 1'b0;
    bus.core_re = 1'b0;
    bus.core_a  = 6'd0;
    bus.core_di = 8'h00;
    w_step_inc  = 1'b0;
    w_set_al    = 1'b0;
    w_set_nack  = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_OFF:   if (r_en) w_next = S_INIT;
      S_INIT: begin
        bus.core_we = 1'b1;
        bus.core_a  = {4'd0, r_init_cnt};
        bus.core_di = (r_init_cnt == 2'd0) ? r_prescale[7:0] :
                      (r_init_cnt == 2'd1) ? r_prescale[15:8] : 8'h80;
        if (r_init_cnt == 2'd2) w_next = S_IDLE;
      end
      S_IDLE:  if (w_go) w_next = S_TX;
      S_TX: begin
        bus.core_we = 1'b1;
        bus.core_a  = 6'd3;
        bus.core_di = w_tx_byte;
        w_next      = S_CR;
      end
      S_CR: begin
        bus.core_we = 1'b1;
        bus.core_a  = 6'd4;
        bus.core_di = w_cr_byte;
        w_next      = S_SRRD;
      end
      S_SRRD: begin
        bus.core_re = 1'b1;
        bus.core_a  = 6'd4;
        w_next      = S_SRCHK;
      end
      S_SRCHK: begin
        if (bus.core_do[1]) begin
          w_next = S_SRRD;
        end else if (bus.core_do[5]) begin
          w_set_al = 1'b1;
          w_next   = S_IDLE;
        end else if (bus.core_do[7] && !w_final_rd) begin
          w_set_nack = 1'b1;
          w_next     = S_STOP;
        end else if (w_last_step) begin
          w_next = r_is_read ? S_RXRD : S_IDLE;
        end else begin
          w_step_inc = 1'b1;
          // The final read step has no TXR byte, so it starts straight at CR.
          w_next     = (r_is_read && (r_step == 2'd2)) ? S_CR : S_TX;
        end
      end
      S_STOP: begin
        bus.core_we = 1'b1;
        bus.core_a  = 6'd4;
        bus.core_di = 8'h40;
        w_next      = S_STWAIT;
      end
      S_STWAIT: begin
        if (!r_stw_chk) begin
          bus.core_re = 1'b1;
          bus.core_a  = 6'd4;
        end else if (!bus.core_do[6]) begin
          w_next = S_IDLE;
        end
      end
      S_RXRD: begin
        bus.core_re = 1'b1;
        bus.core_a  = 6'd3;
        w_next      = S_RXCAP;
      end
      S_RXCAP: begin
        w_capture = 1'b1;
        w_next    = S_IDLE;
      end
      S_DIS: begin
        bus.core_we = 1'b1;
        bus.core_a  = 6'd2;
        w_next      = S_OFF;
      end
      default: w_next = S_OFF;
    endcase
    if (!r_en && (r_state != S_OFF) && (r_state != S_DIS)) w_next = S_DIS;
  end

  assign w_done_set = (w_next == S_IDLE) && (r_state inside {S_SRCHK, S_STWAIT, S_RXCAP});

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_OFF;
      r_init_cnt <= 2'd0;
      r_stw_chk  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= (r_state == S_INIT) ? r_init_cnt + 2'd1 : 2'd0;
      r_stw_chk  <= (r_state == S_STWAIT) ? ~r_stw_chk : 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prescale <= PRESCALE_RST;
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_saddr    <= 7'd0;
      r_regaddr  <= 8'd0;
      r_wdata    <= 8'd0;
      r_rdata    <= 8'd0;
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_al       <= 1'b0;
      r_is_read  <= 1'b0;
      r_step     <= 2'd0;
    end else begin
      if (w_wr) begin
        unique case (w_idx)
          3'd0:    if (!w_busy) r_prescale <= bus.PWDATA[15:0];
          3'd1:    begin r_en <= bus.PWDATA[0]; r_ie <= bus.PWDATA[1]; end
          3'd2:    if (!w_busy) r_saddr <= bus.PWDATA[6:0];
          3'd3:    if (!w_busy) r_regaddr <= bus.PWDATA[7:0];
          3'd4:    if (!w_busy) r_wdata <= bus.PWDATA[7:0];
          3'd6:    if (bus.PWDATA[1]) r_done <= 1'b0;
          default: ;
        endcase
      end
      if (w_go) begin
        r_is_read <= bus.PWDATA[1];
        r_nack    <= 1'b0;
        r_al      <= 1'b0;
        r_done    <= 1'b0;
        r_step    <= 2'd0;
      end
      if (w_step_inc) r_step  <= r_step + 2'd1;
      if (w_set_al)   r_al    <= 1'b1;
      if (w_set_nack) r_nack  <= 1'b1;
      if (w_capture)  r_rdata <= bus.core_do;
      // Placed after the software clear so a coincident completion wins.
      if (w_done_set) r_done  <= 1'b1;
    end
  end

  always_comb begin
    unique case (w_idx)
      3'd0:    bus.PRDATA = {16'd0, r_prescale};
      3'd1:    bus.PRDATA = {30'd0, r_ie, r_en};
      3'd2:    bus.PRDATA = {25'd0, r_saddr};
      3'd3:    bus.PRDATA = {24'd0, r_regaddr};
      3'd4:    bus.PRDATA = {24'd0, r_wdata};
      3'd6:    bus.PRDATA = {16'd0, r_rdata, 4'd0, r_al, r_nack, r_done, w_busy};
      default: bus.PRDATA = 32'd0;
    endcase
  end

  assign bus.PREADY = 1'b1;
  assign bus.PIRQ   = r_done & r_ie;

endmodule
